// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_if
// Brief  : Requester/BRAM bundle for the data-memory port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              i_cpu_req;
    logic [3:0]        i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_adr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_gnt;
    logic              o_cpu_rvalid;
    logic [DATA_W-1:0] o_cpu_rdata;

    logic              i_dma_req;
    logic [3:0]        i_dma_we;
    logic [ADDR_W-1:0] i_dma_adr;
    logic [DATA_W-1:0] i_dma_wdata;
    logic              o_dma_gnt;
    logic              o_dma_rvalid;
    logic [DATA_W-1:0] o_dma_rdata;

    logic              o_mem_en;
    logic [3:0]        o_mem_we;
    logic [ADDR_W-1:0] o_mem_adr;
    logic [DATA_W-1:0] o_mem_din;
    logic [DATA_W-1:0] i_mem_dout;

    // Requesters and the BRAM sit on the master side.
    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_adr, i_cpu_wdata,
        input  o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
        output i_dma_req, i_dma_we, i_dma_adr, i_dma_wdata,
        input  o_dma_gnt, o_dma_rvalid, o_dma_rdata,
        input  o_mem_en, o_mem_we, o_mem_adr, o_mem_din,
        output i_mem_dout
    );

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_adr, i_cpu_wdata,
        output o_cpu_gnt, o_cpu_rvalid, o_cpu_rdata,
        input  i_dma_req, i_dma_we, i_dma_adr, i_dma_wdata,
        output o_dma_gnt, o_dma_rvalid, o_dma_rdata,
        output o_mem_en, o_mem_we, o_mem_adr, o_mem_din,
        input  i_mem_dout
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : CPU/DMA arbiter for the single dmem BRAM port with DMA anti-starvation.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        CPU_PRIO = 1'b0,
        DMA_PRIO = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_DMA  = 2'd2
    } rtag_t;

    localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    rtag_t             r_rtag;
    logic [3:0]        r_wait_cnt;

    logic              w_cpu_gnt;
    logic              w_dma_gnt;
    logic [3:0]        w_wait_nxt;
    logic [3:0]        w_mem_we;
    logic [ADDR_W-1:0] w_mem_adr;
    logic [DATA_W-1:0] w_mem_din;

    always_comb begin
        // Grants are gated by rst_n so nothing reaches the BRAM while in reset.
        w_cpu_gnt = rst_n & bus.i_cpu_req & (~bus.i_dma_req | (r_state == CPU_PRIO));
        w_dma_gnt = rst_n & bus.i_dma_req & ~w_cpu_gnt;

        w_wait_nxt = 4'd0;
        if (bus.i_dma_req && !w_dma_gnt) begin
            w_wait_nxt = (r_wait_cnt >= C_LIMIT) ? C_LIMIT : r_wait_cnt + 4'd1;
        end

        w_mem_we  = 4'd0;
        w_mem_adr = '0;
        w_mem_din = '0;
        if (w_cpu_gnt) begin
            w_mem_we  = bus.i_cpu_we;
            w_mem_adr = bus.i_cpu_adr;
            w_mem_din = bus.i_cpu_wdata;
        end else if (w_dma_gnt) begin
            w_mem_we  = bus.i_dma_we;
            w_mem_adr = bus.i_dma_adr;
            w_mem_din = bus.i_dma_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= CPU_PRIO;
            r_wait_cnt <= 4'd0;
            r_rtag     <= TAG_NONE;
        end else begin
            r_wait_cnt <= w_wait_nxt;

            case (r_state)
                CPU_PRIO: if (w_wait_nxt == C_LIMIT) r_state <= DMA_PRIO;
                DMA_PRIO: if (w_dma_gnt || !bus.i_dma_req) r_state <= CPU_PRIO;
                default:  r_state <= CPU_PRIO;
            endcase

            if (w_cpu_gnt && bus.i_cpu_we == 4'd0) begin
                r_rtag <= TAG_CPU;
            end else if (w_dma_gnt && bus.i_dma_we == 4'd0) begin
                r_rtag <= TAG_DMA;
            end else begin
                r_rtag <= TAG_NONE;
            end
        end
    end

    assign bus.o_cpu_gnt    = w_cpu_gnt;
    assign bus.o_dma_gnt    = w_dma_gnt;
    assign bus.o_cpu_rvalid = (r_rtag == TAG_CPU);
    assign bus.o_dma_rvalid = (r_rtag == TAG_DMA);
    assign bus.o_cpu_rdata  = bus.i_mem_dout;
    assign bus.o_dma_rdata  = bus.i_mem_dout;
    assign bus.o_mem_en     = w_cpu_gnt | w_dma_gnt;
    assign bus.o_mem_we     = w_mem_we;
    assign bus.o_mem_adr    = w_mem_adr;
    assign bus.o_mem_din    = w_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed self-checking bench for mem_port_arbiter with a BRAM model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem [0:4095];

    mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (12),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first BRAM with byte enables and 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.o_mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.o_mem_we[b]) mem[bus.o_mem_adr][8*b +: 8] <= bus.o_mem_din[8*b +: 8];
            end
            bus.i_mem_dout <= mem[bus.o_mem_adr];
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        assert (!(bus.o_cpu_gnt && bus.o_dma_gnt)) else begin
            n_err++;
            $error("FAIL gnt_onehot: observed cpu_gnt=%0b dma_gnt=%0b expected not both", bus.o_cpu_gnt, bus.o_dma_gnt);
        end
        n_cmp++;
        assert (!(bus.o_cpu_rvalid && bus.o_dma_rvalid)) else begin
            n_err++;
            $error("FAIL rvalid_onehot: observed cpu_rvalid=%0b dma_rvalid=%0b expected not both", bus.o_cpu_rvalid, bus.o_dma_rvalid);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[1]  = 32'h1234_5678;
        mem[16] = 32'h1111_0010;
        mem[32] = 32'h2222_0020;
        bus.i_mem_dout = 32'h0;

        // Reset with both requesting
        rst_n = 1'b0;
        bus.i_cpu_req = 1'b1; bus.i_cpu_we = 4'd0; bus.i_cpu_adr = 12'h000; bus.i_cpu_wdata = 32'h0;
        bus.i_dma_req = 1'b1; bus.i_dma_we = 4'd0; bus.i_dma_adr = 12'h000; bus.i_dma_wdata = 32'h0;
        #1;
        chk("rst_cpu_gnt", bus.o_cpu_gnt, 1'b0);
        chk("rst_dma_gnt", bus.o_dma_gnt, 1'b0);
        chk("rst_mem_en", bus.o_mem_en, 1'b0);
        chk("rst_mem_we", bus.o_mem_we, 4'h0);
        chk("rst_cpu_rvalid", bus.o_cpu_rvalid, 1'b0);
        chk("rst_dma_rvalid", bus.o_dma_rvalid, 1'b0);
        cyc();
        chk("rst_rvalid_after_edge", bus.o_cpu_rvalid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cpu_gnt", bus.o_cpu_gnt, 1'b1);
        chk("post_rst_dma_gnt", bus.o_dma_gnt, 1'b0);
        chk("post_rst_mem_en", bus.o_mem_en, 1'b1);
        cyc();

        // CPU byte store then read back
        bus.i_dma_req = 1'b0;
        bus.i_cpu_we = 4'b0100; bus.i_cpu_adr = 12'h001; bus.i_cpu_wdata = 32'hbeef_0000;
        #1;
        chk("st_cpu_gnt", bus.o_cpu_gnt, 1'b1);
        chk("st_mem_we", bus.o_mem_we, 4'b0100);
        chk("st_mem_adr", bus.o_mem_adr, 12'h001);
        chk("st_mem_din", bus.o_mem_din, 32'hbeef_0000);
        chk("st_dma_rvalid", bus.o_dma_rvalid, 1'b0);
        cyc();
        chk("st_no_rvalid", bus.o_cpu_rvalid, 1'b0);
        bus.i_cpu_we = 4'b0000;
        #1;
        chk("ld_cpu_gnt", bus.o_cpu_gnt, 1'b1);
        cyc();
        bus.i_cpu_req = 1'b0;
        #1;
        chk("ld_cpu_rvalid", bus.o_cpu_rvalid, 1'b1);
        chk("ld_dma_rvalid", bus.o_dma_rvalid, 1'b0);
        chk("ld_cpu_rdata", bus.o_cpu_rdata, 32'h12ef_5678);
        chk("idle_mem_en", bus.o_mem_en, 1'b0);
        chk("idle_mem_adr", bus.o_mem_adr, 12'h000);
        chk("idle_mem_din", bus.o_mem_din, 32'h0);
        cyc();

        // Starvation under continuous CPU traffic
        bus.i_cpu_req = 1'b1; bus.i_cpu_adr = 12'h000;
        bus.i_dma_req = 1'b1; bus.i_dma_adr = 12'h010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("starve_cpu_gnt", bus.o_cpu_gnt, 1'b1);
            chk("starve_dma_gnt", bus.o_dma_gnt, 1'b0);
            cyc();
        end
        #1;
        chk("starve_dma_wins", bus.o_dma_gnt, 1'b1);
        chk("starve_cpu_stall", bus.o_cpu_gnt, 1'b0);
        chk("starve_mem_adr", bus.o_mem_adr, 12'h010);
        cyc();
        bus.i_dma_req = 1'b0;
        #1;
        chk("starve_cpu_back", bus.o_cpu_gnt, 1'b1);
        chk("starve_dma_rvalid", bus.o_dma_rvalid, 1'b1);
        chk("starve_dma_rdata", bus.o_dma_rdata, 32'h1111_0010);
        cyc();
        bus.i_cpu_req = 1'b0;
        cyc();

        // Read steering: DMA then CPU on consecutive cycles
        bus.i_dma_req = 1'b1; bus.i_dma_adr = 12'h010;
        #1;
        chk("steer_dma_gnt", bus.o_dma_gnt, 1'b1);
        cyc();
        bus.i_dma_req = 1'b0;
        bus.i_cpu_req = 1'b1; bus.i_cpu_adr = 12'h020;
        #1;
        chk("steer_cpu_gnt", bus.o_cpu_gnt, 1'b1);
        chk("steer_dma_rvalid", bus.o_dma_rvalid, 1'b1);
        chk("steer_cpu_rvalid0", bus.o_cpu_rvalid, 1'b0);
        chk("steer_dma_rdata", bus.o_dma_rdata, 32'h1111_0010);
        cyc();
        bus.i_cpu_req = 1'b0;
        #1;
        chk("steer_cpu_rvalid", bus.o_cpu_rvalid, 1'b1);
        chk("steer_dma_rvalid0", bus.o_dma_rvalid, 1'b0);
        chk("steer_cpu_rdata", bus.o_cpu_rdata, 32'h2222_0020);
        cyc();
        chk("steer_quiet_cpu", bus.o_cpu_rvalid, 1'b0);
        chk("steer_quiet_dma", bus.o_dma_rvalid, 1'b0);

        // Abandoned DMA request must leave the counter cleared
        bus.i_cpu_req = 1'b1; bus.i_cpu_adr = 12'h000;
        bus.i_dma_req = 1'b1; bus.i_dma_adr = 12'h010;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("aband_dma_gnt", bus.o_dma_gnt, 1'b0);
            cyc();
        end
        bus.i_dma_req = 1'b0;
        #1;
        chk("aband_cpu_gnt", bus.o_cpu_gnt, 1'b1);
        chk("aband_no_dma_gnt", bus.o_dma_gnt, 1'b0);
        cyc();
        bus.i_dma_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("aband_full_wait_dma", bus.o_dma_gnt, 1'b0);
            chk("aband_full_wait_cpu", bus.o_cpu_gnt, 1'b1);
            cyc();
        end
        #1;
        chk("aband_dma_after_limit", bus.o_dma_gnt, 1'b1);
        cyc();
        bus.i_dma_req = 1'b0; bus.i_cpu_req = 1'b0;
        cyc();

        // Mid-operation reset drops the in-flight read
        bus.i_cpu_req = 1'b1; bus.i_cpu_adr = 12'h001;
        #1;
        chk("mid_cpu_gnt", bus.o_cpu_gnt, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cpu_gnt", bus.o_cpu_gnt, 1'b0);
        chk("mid_rst_mem_en", bus.o_mem_en, 1'b0);
        cyc();
        chk("mid_rst_no_rvalid", bus.o_cpu_rvalid, 1'b0);
        rst_n = 1'b1;
        bus.i_dma_req = 1'b1;
        #1;
        chk("mid_post_cpu_prio", bus.o_cpu_gnt, 1'b1);
        chk("mid_post_dma_gnt", bus.o_dma_gnt, 1'b0);
        cyc();
        bus.i_cpu_req = 1'b0; bus.i_dma_req = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory BRAM port between two requesters: the CPU load/store path and the DMA/bootloader port. Byte enables, word address and pre-shifted store data come from the CPU's address-for-memory stage. The arbiter grants one requester per cycle and steers the 1-cycle-latency read data back to the owner. It also guarantees the DMA port cannot be starved by back-to-back CPU accesses. It sits between the MEM pipeline stage and the dmem block RAM; a low cpu_gnt is the CPU stall source.

## Interface
- ADDR_W, 12, word address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied DMA cycles before DMA takes priority (1..15)

- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  4  CPU byte write enables (0000 = read)
- cpu_adr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU store data, already lane-shifted
- cpu_gnt  out  1  CPU access accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  CPU read data
- dma_req, dma_we, dma_adr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* ports, for the DMA port
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_adr  out  ADDR_W  BRAM address
- mem_din  out  DATA_W  BRAM write data
- mem_dout  in  DATA_W  BRAM read data, valid the cycle after a read

## Operation
**Transactions**
- A transaction is accepted in the cycle its gnt is high.
- A requester holds req, we, adr and wdata stable until gnt.
- A requester may drop req without having been granted; nothing is issued in that case.

**Grant and memory drive**
- At most one gnt is high per cycle. Grants are combinational from req and registered state.
- mem_en = cpu_gnt | dma_gnt.
- mem_we, mem_adr and mem_din are muxed from the granted port.
- When nothing is granted: mem_we = 0, mem_adr = 0, mem_din = 0.

**State machine, 2 states**
- CPU_PRIO (reset state): on conflict, CPU wins.
- DMA_PRIO: on conflict, DMA wins.
- Lone requester is always granted, in either state.

**Starvation counter**
- wait_cnt is 4 bits.
- If dma_req=1 and dma_gnt=0: wait_cnt increments, saturating at STARVE_LIMIT.
- If dma_gnt=1 or dma_req=0: wait_cnt clears to 0.

**State transitions**
- CPU_PRIO -> DMA_PRIO on the edge where the next wait_cnt equals STARVE_LIMIT.
- DMA_PRIO -> CPU_PRIO on the edge after any dma_gnt, or when dma_req=0.

**Read return**
- Registered tag rtag ∈ {NONE, CPU, DMA}.
- rtag is set to the granted port when the granted we = 0000; otherwise it is NONE.
- cpu_rvalid = (rtag == CPU); dma_rvalid = (rtag == DMA).
- Both rdata ports carry mem_dout combinationally. Their value is meaningful only with rvalid.
- Writes produce no rvalid.

**Reset**
- Reset_n low asynchronously sets: state CPU_PRIO, wait_cnt 0, rtag NONE.
- While Reset_n is low, all gnt, mem_en, mem_we and rvalid outputs are forced to 0, regardless of req.
- A read granted in the cycle before reset asserts returns no rvalid.

## Timing
- Grant latency: 0 cycles. gnt is valid in the same cycle as req, so the CPU stalls only in conflict cycles.
- Read latency: rvalid and rdata arrive exactly 1 cycle after the granted cycle.
- Write latency: data is written at the granted cycle's clock edge.
- Throughput: 1 transaction per cycle. Back-to-back reads from alternating ports return in order, 1 per cycle.
- Worst-case DMA wait under continuous CPU traffic is STARVE_LIMIT cycles; DMA is granted in cycle STARVE_LIMIT+1.
- Same-cycle conflict in DMA_PRIO: DMA granted, CPU stalls 1 cycle. The CPU's wait does not feed any counter.

## Test plan
1. **Reset.** Reset_n=0 with cpu_req=dma_req=1 -> cpu_gnt=dma_gnt=0, mem_en=0, rvalid=0. After release, the first cycle grants the CPU.
2. **CPU byte store then read.**
   - Cycle 1: CPU store with cpu_we=0100, cpu_adr=12'h001, cpu_wdata=32'hbeef0000 -> cpu_gnt=1 and mem_we=0100 in the same cycle.
   - Cycle 2: CPU read of 12'h001 -> next cycle cpu_rvalid=1, cpu_rdata byte 2 = 8'hef, dma_rvalid=0.
3. **Starvation.** cpu_req=1 continuously, dma_req=1 from cycle 0, STARVE_LIMIT=4 -> cpu_gnt in cycles 0–3, dma_gnt=1 and cpu_gnt=0 in cycle 4, cpu_gnt again from cycle 5, wait_cnt=0.
4. **Read steering.** DMA read of adr 12'h010 granted, then CPU read of adr 12'h020 the next cycle -> dma_rvalid then cpu_rvalid on consecutive cycles, each with its own word, never both high.
5. **Abandoned request.** dma_req=1 for 2 denied cycles, then 0 -> wait_cnt returns to 0, state stays CPU_PRIO, no dma_gnt.
6. **Mid-operation reset.** CPU read granted, then Reset_n asserted before the next edge -> cpu_rvalid stays 0, state is CPU_PRIO after release.
